// File: rtl/game_timer_pkg.sv
// Shared types and constants for the round timer: FSM states, mode encoding and
// counter widths used by game_timer and its prescaler.
package game_timer_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRun    = 2'd1,
      StPaused = 2'd2,
      StDone   = 2'd3
   } timer_state_e;

   localparam logic ModeFree    = 1'b0;
   localparam logic ModeLimited = 1'b1;

   localparam int unsigned SecW = 10;
   localparam int unsigned RemW = 3;

   localparam logic [SecW-1:0] SecMax      = '1;
   localparam int unsigned     LimitedTime = 60;

   // Seconds counter saturates rather than wrapping.
   function automatic logic [SecW-1:0] sec_sat_inc(input logic [SecW-1:0] s);
      return (s == SecMax) ? s : s + SecW'(1);
   endfunction

endpackage

// File: rtl/game_timer_eighth_prescaler.sv
// Divides the system clock down to eighth-second strobes; tc is high in the
// terminal-count cycle while enabled.
module game_timer_eighth_prescaler
   import game_timer_pkg::*;
#(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int unsigned    CntW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tc = en && (cnt_q == Last);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tc ? '0 : cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/game_timer.sv
// Round timer: sequences IDLE/RUN/PAUSED/DONE and produces elapsed seconds plus
// the eighth-second phase, freezing on win or LIMITED-mode time-out.
module game_timer
   import game_timer_pkg::*;
#(
   parameter int unsigned EIGHTH_DIV = 12_500_000,
   parameter int unsigned LIMIT      = LimitedTime
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            pause,
   input  logic            mode,
   input  logic            win,
   output logic [SecW-1:0] sec,
   output logic [RemW-1:0] remainder,
   output logic            tick,
   output logic            running,
   output logic            time_up,
   output logic            won
);

   localparam logic [SecW-1:0] LimitW = SecW'(LIMIT);

   timer_state_e    state_q, state_d;
   logic [SecW-1:0] sec_q, sec_d;
   logic [RemW-1:0] rem_q, rem_d;
   logic            tick_q, tick_d;
   logic            time_up_q, time_up_d;
   logic            won_q, won_d;
   logic            mode_q, mode_d;
   logic            pre_clr, pre_en, pre_tc;

   // Leaving PAUSED advances the prescaler on the same edge, so time resumes at once.
   assign pre_clr = start;
   assign pre_en  = !start && !win && !pause && ((state_q == StRun) || (state_q == StPaused));

   game_timer_eighth_prescaler #(
      .DIV (EIGHTH_DIV)
   ) u_prescaler (
      .clk (clk),
      .rst (rst),
      .clr (pre_clr),
      .en  (pre_en),
      .tc  (pre_tc)
   );

   always_comb begin
      state_d   = state_q;
      sec_d     = sec_q;
      rem_d     = rem_q;
      tick_d    = 1'b0;
      time_up_d = time_up_q;
      won_d     = won_q;
      mode_d    = mode_q;
      if (start) begin
         mode_d    = mode;
         sec_d     = '0;
         rem_d     = '0;
         won_d     = 1'b0;
         time_up_d = 1'b0;
         if ((mode == ModeLimited) && (LimitW == '0)) begin
            state_d   = StDone;
            time_up_d = 1'b1;
         end else begin
            state_d = StRun;
         end
      end else begin
         unique case (state_q)
            StRun, StPaused: begin
               if (win) begin
                  state_d = StDone;
                  won_d   = 1'b1;
               end else if (pause) begin
                  state_d = StPaused;
               end else begin
                  state_d = StRun;
                  if (pre_tc) begin
                     tick_d = 1'b1;
                     rem_d  = rem_q + RemW'(1);
                     if (rem_q == '1) begin
                        sec_d = sec_sat_inc(sec_q);
                        if ((mode_q == ModeLimited) && (sec_q != SecMax) && (sec_d == LimitW)) begin
                           state_d   = StDone;
                           time_up_d = 1'b1;
                        end
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         sec_q     <= '0;
         rem_q     <= '0;
         tick_q    <= 1'b0;
         time_up_q <= 1'b0;
         won_q     <= 1'b0;
         mode_q    <= ModeFree;
      end else begin
         state_q   <= state_d;
         sec_q     <= sec_d;
         rem_q     <= rem_d;
         tick_q    <= tick_d;
         time_up_q <= time_up_d;
         won_q     <= won_d;
         mode_q    <= mode_d;
      end
   end

   assign sec       = sec_q;
   assign remainder = rem_q;
   assign tick      = tick_q;
   assign running   = (state_q == StRun);
   assign time_up   = time_up_q;
   assign won       = won_q;

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer with EIGHTH_DIV=4, LIMIT=3: expected tick values are queued
// by the stimulus and popped by a monitor on every tick.
module tb_game_timer;
   import game_timer_pkg::*;

   logic       clk = 1'b0;
   logic       rst, start, pause, mode, win;
   logic [9:0] sec;
   logic [2:0] remainder;
   logic       tick, running, time_up, won;

   int checks   = 0;
   int failures = 0;

   logic [12:0] exp_q[$];
   logic [12:0] exp_e;

   game_timer #(
      .EIGHTH_DIV (4),
      .LIMIT      (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pause     (pause),
      .mode      (mode),
      .win       (win),
      .sec       (sec),
      .remainder (remainder),
      .tick      (tick),
      .running   (running),
      .time_up   (time_up),
      .won       (won)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Queue ticks n0..n1 counted from a start edge: tick n shows sec=n/8, rem=n%8.
   task automatic push_ticks(input int n0, input int n1);
      for (int n = n0; n <= n1; n++) exp_q.push_back({10'(n / 8), 3'(n % 8)});
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic m);
      start = 1'b1;
      mode  = m;
      edges(1);
      start = 1'b0;
      mode  = ~m;
   endtask

   always @(negedge clk) begin
      if (!rst && tick) begin
         check("tick_expected", int'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            exp_e = exp_q.pop_front();
            check("tick_sec", int'(sec), int'(exp_e[12:3]));
            check("tick_rem", int'(remainder), int'(exp_e[2:0]));
         end
      end
   end

   initial begin
      rst = 1'b0; start = 1'b0; pause = 1'b0; mode = ModeFree; win = 1'b0;
      #1 rst = 1'b1;
      #2;
      check("rst_sec", int'(sec), 0);
      check("rst_running", int'(running), 0);
      check("rst_flags", int'({tick, time_up, won}), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      edges(1);

      // FREE run, then a 10-cycle pause with the prescaler at 2.
      push_ticks(1, 8);
      do_start(ModeFree);
      edges(4);
      check("free_rem_at4", int'(remainder), 1);
      check("free_running", int'(running), 1);
      edges(28);
      check("free_sec_at32", int'(sec), 1);
      check("free_rem_at32", int'(remainder), 0);
      edges(2);
      pause = 1'b1;
      edges(1);
      check("pause_running", int'(running), 0);
      edges(9);
      check("pause_sec_hold", int'(sec), 1);
      check("pause_rem_hold", int'(remainder), 0);
      pause = 1'b0;
      exp_q.push_back({10'd1, 3'd1});
      edges(1);
      check("resume_running", int'(running), 1);
      edges(1);
      check("resume_rem", int'(remainder), 1);
      edges(2);

      // Asynchronous reset in the middle of a round at sec=2.
      push_ticks(1, 16);
      do_start(ModeFree);
      edges(64);
      check("pre_rst_sec", int'(sec), 2);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("async_rst_sec", int'(sec), 0);
      check("async_rst_rem", int'(remainder), 0);
      check("async_rst_running", int'(running), 0);
      check("async_rst_flags", int'({tick, time_up, won}), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      edges(2);
      check("post_rst_idle", int'(running), 0);

      // LIMITED round times out at sec=3; DONE ignores win.
      push_ticks(1, 24);
      do_start(ModeLimited);
      edges(96);
      check("lim_sec", int'(sec), 3);
      check("lim_rem", int'(remainder), 0);
      check("lim_time_up", int'(time_up), 1);
      check("lim_running", int'(running), 0);
      check("lim_won", int'(won), 0);
      edges(25);
      win = 1'b1;
      edges(1);
      win = 1'b0;
      edges(24);
      check("lim_hold_sec", int'(sec), 3);
      check("lim_hold_time_up", int'(time_up), 1);
      check("lim_hold_won", int'(won), 0);

      // win on the same edge as the LIMIT crossing wins.
      push_ticks(1, 23);
      do_start(ModeLimited);
      edges(95);
      win = 1'b1;
      edges(1);
      win = 1'b0;
      check("win_won", int'(won), 1);
      check("win_time_up", int'(time_up), 0);
      check("win_sec", int'(sec), 2);
      check("win_rem", int'(remainder), 7);
      check("win_tick", int'(tick), 0);

      // Restart from DONE.
      exp_q.push_back({10'd0, 3'd1});
      do_start(ModeFree);
      check("restart_sec", int'(sec), 0);
      check("restart_rem", int'(remainder), 0);
      check("restart_flags", int'({won, time_up}), 0);
      check("restart_running", int'(running), 1);
      edges(4);
      check("restart_rem_at4", int'(remainder), 1);
      edges(3);

      check("ticks_all_seen", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
